// File: rtl/poly_note_player.sv
// Polyphonic note player: allocates loads to free voices, times each note on the beat,
// and mixes per-voice samples into a saturated stereo pair per codec request.
//   state | meaning
//   IDLE  | free, allocatable
//   LOAD  | note captured, phase increment lookup in flight
//   PLAY  | counting beats, answers sample requests
//   PAUSE | play_enable low, count frozen
module poly_note_player #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic                       load_new_note,
    input  logic [NOTE_W-1:0]          note_to_load,
    input  logic [DUR_W-1:0]           duration_to_load,
    input  logic [1:0]                 stereo_side_to_load,
    output logic                       load_accepted,
    output logic                       load_rejected,
    output logic [NUM_VOICES-1:0]      voices_busy,
    output logic [NUM_VOICES-1:0]      done_mask,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic signed [SAMPLE_W-1:0] sample_left,
    output logic signed [SAMPLE_W-1:0] sample_right,
    output logic                       new_sample_ready
);
    localparam int PHASE_W = 16;
    localparam int SUM_W   = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam logic signed [SUM_W-1:0]    SAT_MAX = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0]    SAT_MIN = ~SAT_MAX;
    localparam logic signed [SAMPLE_W-1:0] WAVE_HI = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] WAVE_LO = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, PAUSE} voice_state_t;

    voice_state_t               state      [NUM_VOICES];
    voice_state_t               state_next [NUM_VOICES];
    logic [DUR_W-1:0]           count      [NUM_VOICES];
    logic [DUR_W-1:0]           count_next [NUM_VOICES];
    logic [NOTE_W-1:0]          note       [NUM_VOICES];
    logic [1:0]                 stereo     [NUM_VOICES];
    logic [PHASE_W-1:0]         step       [NUM_VOICES];
    logic [PHASE_W-1:0]         phase      [NUM_VOICES];
    logic [PHASE_W-1:0]         phase_adv  [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] wave       [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] latched    [NUM_VOICES];

    logic [NUM_VOICES-1:0] idle_mask, play_mask, left_sel, right_sel, alloc_mask, capture;
    logic [NUM_VOICES-1:0] done_next, gen_voice, wave_ready, pending, mix_left, mix_right;
    logic                  load_ok, req_ok, mix_active;
    logic signed [SUM_W-1:0] left_sum, right_sum;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] c;
        c = v;
        if (v > SAT_MAX) c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        return c[SAMPLE_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            idle_mask[i] = (state[i] == IDLE);
            play_mask[i] = (state[i] == PLAY);
            left_sel[i]  = stereo[i][1];
            right_sel[i] = stereo[i][0];
            phase_adv[i] = phase[i] + step[i];
        end
    end

    // lowest set bit of the idle mask picks the voice
    assign alloc_mask    = idle_mask & (~idle_mask + NUM_VOICES'(1));
    assign load_ok       = load_new_note && !reset && (duration_to_load != '0) && (idle_mask != '0);
    assign capture       = load_ok ? alloc_mask : '0;
    assign load_accepted = load_ok;
    assign load_rejected = load_new_note && !reset && !load_ok;
    assign voices_busy   = ~idle_mask;
    assign req_ok        = generate_next_sample && !reset && !mix_active;
    assign gen_voice     = req_ok ? play_mask : '0;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            state_next[i] = state[i];
            count_next[i] = count[i];
            done_next[i]  = 1'b0;
            case (state[i])
                IDLE: if (capture[i]) begin
                    state_next[i] = LOAD;
                    count_next[i] = duration_to_load - DUR_W'(1);
                end
                LOAD: state_next[i] = play_enable ? PLAY : PAUSE;
                PLAY: begin
                    if (!play_enable) begin
                        state_next[i] = PAUSE;
                    end else if (beat) begin
                        if (count[i] == '0) begin
                            state_next[i] = IDLE;
                            done_next[i]  = 1'b1;
                        end else begin
                            count_next[i] = count[i] - DUR_W'(1);
                        end
                    end
                end
                PAUSE: if (play_enable) state_next[i] = PLAY;
                default: state_next[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state[i]  <= IDLE;
                count[i]  <= '0;
                note[i]   <= '0;
                stereo[i] <= '0;
            end
            done_mask <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state[i] <= state_next[i];
                count[i] <= count_next[i];
                if (capture[i]) begin
                    note[i]   <= note_to_load;
                    stereo[i] <= stereo_side_to_load;
                end
            end
            done_mask <= done_next;
        end
    end

    // Per-voice frequency ROM (registered, 1 cycle) and sine reader (1 cycle latency).
    // The reader is a full-scale square wave from the phase MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                step[i]  <= '0;
                phase[i] <= '0;
                wave[i]  <= '0;
            end
            wave_ready <= '0;
        end else begin
            wave_ready <= gen_voice;
            for (int i = 0; i < NUM_VOICES; i++) begin
                step[i] <= PHASE_W'(note[i]) << (PHASE_W - NOTE_W);
                if (capture[i]) begin
                    phase[i] <= '0;
                end else if (gen_voice[i]) begin
                    phase[i] <= phase_adv[i];
                    wave[i]  <= phase_adv[i][PHASE_W-1] ? WAVE_LO : WAVE_HI;
                end
            end
        end
    end

    always_comb begin
        left_sum  = '0;
        right_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (mix_left[i])  left_sum  = left_sum  + SUM_W'(latched[i]);
            if (mix_right[i]) right_sum = right_sum + SUM_W'(latched[i]);
        end
    end

    // Channel masks are captured at request time so a voice reloaded mid-mix cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) latched[i] <= '0;
            pending          <= '0;
            mix_active       <= 1'b0;
            mix_left         <= '0;
            mix_right        <= '0;
            sample_left      <= '0;
            sample_right     <= '0;
            new_sample_ready <= 1'b0;
        end else begin
            new_sample_ready <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (wave_ready[i]) latched[i] <= wave[i];
            end
            pending <= (pending & ~wave_ready) | gen_voice;
            if (req_ok) begin
                mix_active <= 1'b1;
                mix_left   <= play_mask & left_sel;
                mix_right  <= play_mask & right_sel;
            end else if (mix_active && pending == '0) begin
                mix_active       <= 1'b0;
                sample_left      <= saturate(left_sum >>> GAIN_SHIFT);
                sample_right     <= saturate(right_sum >>> GAIN_SHIFT);
                new_sample_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: two instances (gain shift 2 and 0) on shared stimulus,
// mix results predicted at request time and matched on new_sample_ready.
module tb_poly_note_player;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, play_enable, load_new_note, beat, generate_next_sample;
    logic [5:0]  note_to_load, duration_to_load;
    logic [1:0]  stereo_side_to_load;
    logic        load_accepted, load_rejected, new_sample_ready;
    logic [3:0]  voices_busy, done_mask;
    logic [15:0] sample_left, sample_right;
    logic        load_accepted_g0, load_rejected_g0, new_sample_ready_g0;
    logic [3:0]  voices_busy_g0, done_mask_g0;
    logic [15:0] sample_left_g0, sample_right_g0;

    poly_note_player #(.GAIN_SHIFT(2)) u_dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .stereo_side_to_load(stereo_side_to_load), .load_accepted(load_accepted),
        .load_rejected(load_rejected), .voices_busy(voices_busy), .done_mask(done_mask),
        .beat(beat), .generate_next_sample(generate_next_sample), .sample_left(sample_left),
        .sample_right(sample_right), .new_sample_ready(new_sample_ready)
    );

    poly_note_player #(.GAIN_SHIFT(0)) u_dut_g0 (
        .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .stereo_side_to_load(stereo_side_to_load), .load_accepted(load_accepted_g0),
        .load_rejected(load_rejected_g0), .voices_busy(voices_busy_g0), .done_mask(done_mask_g0),
        .beat(beat), .generate_next_sample(generate_next_sample), .sample_left(sample_left_g0),
        .sample_right(sample_right_g0), .new_sample_ready(new_sample_ready_g0)
    );

    typedef struct {
        int          due;
        logic [15:0] l2, r2, l0, r0;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [15:0] m_phase [4];
    logic [15:0] m_step  [4];
    logic [1:0]  m_stereo[4];
    bit          m_playing[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mix_expect(input int sum, input int sh);
        int v;
        v = sum >>> sh;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit  exp_rdy;
        sb_t e;
        exp_rdy = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        if (new_sample_ready || new_sample_ready_g0 || exp_rdy) begin
            check_eq("ready_g2", new_sample_ready, exp_rdy);
            check_eq("ready_g0", new_sample_ready_g0, exp_rdy);
            if (exp_rdy) begin
                e = sb_q.pop_front();
                check_eq("left_g2", sample_left, e.l2);
                check_eq("right_g2", sample_right, e.r2);
                check_eq("left_g0", sample_left_g0, e.l0);
                check_eq("right_g0", sample_right_g0, e.r0);
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int note, input int dur, input logic [1:0] st, input int v,
                        input logic with_beat, input logic [3:0] exp_busy);
        load_new_note       = 1'b1;
        note_to_load        = 6'(note);
        duration_to_load    = 6'(dur);
        stereo_side_to_load = st;
        beat                = with_beat;
        #1;
        check_eq("load_accepted", load_accepted, v >= 0);
        check_eq("load_rejected", load_rejected, v < 0);
        step_cyc();
        load_new_note = 1'b0;
        beat          = 1'b0;
        if (v >= 0) begin
            m_phase[v]  = '0;
            m_step[v]   = 16'(note) << 10;
            m_stereo[v] = st;
        end
        check_eq("voices_busy", voices_busy, exp_busy);
    endtask

    task automatic give_beat(input logic [3:0] exp_done);
        beat = 1'b1;
        step_cyc();
        beat = 1'b0;
        check_eq("done_mask", done_mask, exp_done);
    endtask

    task automatic request(input logic with_beat, input bit twice);
        sb_t e;
        int  l = 0;
        int  r = 0;
        int  s;
        bit  any = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_playing[i]) begin
                m_phase[i] = m_phase[i] + m_step[i];
                s = m_phase[i][15] ? -32768 : 32767;
                any = 1;
                if (m_stereo[i][1]) l += s;
                if (m_stereo[i][0]) r += s;
            end
        end
        e.due = cyc + (any ? 3 : 2);
        e.l2  = mix_expect(l, 2);
        e.r2  = mix_expect(r, 2);
        e.l0  = mix_expect(l, 0);
        e.r0  = mix_expect(r, 0);
        sb_q.push_back(e);
        generate_next_sample = 1'b1;
        beat                 = with_beat;
        step_cyc();
        generate_next_sample = 1'b0;
        beat                 = 1'b0;
        if (twice) begin
            generate_next_sample = 1'b1;
            step_cyc();
            generate_next_sample = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && sb_q.size() > 0; k++) step_cyc();
        check_eq("sb_drained", sb_q.size(), 0);
        step_cyc();
        step_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; play_enable = 1'b1; load_new_note = 1'b0; beat = 1'b0;
        generate_next_sample = 1'b0; note_to_load = '0; duration_to_load = '0;
        stereo_side_to_load = '0;
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = '0; m_step[i] = '0; m_stereo[i] = '0; m_playing[i] = 0;
        end
        repeat (3) step_cyc();
        reset = 1'b0;
        check_eq("rst_busy", voices_busy, 0);
        check_eq("rst_done", done_mask, 0);
        check_eq("rst_left", sample_left, 0);
        check_eq("rst_right", sample_right, 0);
        check_eq("rst_ready", new_sample_ready, 0);
        check_eq("rst_acc", load_accepted, 0);
        check_eq("rst_rej", load_rejected, 0);

        // single note, terminal beat coinciding with a sample request
        load(10, 3, 2'b11, 0, 1'b0, 4'b0001);
        step_cyc();
        m_playing[0] = 1;
        give_beat(4'b0000);
        give_beat(4'b0000);
        request(1'b1, 0);
        check_eq("done_terminal", done_mask, 4'b0001);
        check_eq("busy_after_done", voices_busy, 4'b0000);
        m_playing[0] = 0;
        step_cyc();
        check_eq("done_one_cycle", done_mask, 4'b0000);
        drain();

        // fill all voices, overflow, saturating mixes, simultaneous finish
        load(32, 20, 2'b10, 0, 1'b0, 4'b0001);
        load(32, 20, 2'b10, 1, 1'b0, 4'b0011);
        load(32, 20, 2'b10, 2, 1'b0, 4'b0111);
        load(32, 20, 2'b10, 3, 1'b0, 4'b1111);
        load(32, 20, 2'b10, -1, 1'b0, 4'b1111);
        for (int i = 0; i < 4; i++) m_playing[i] = 1;
        request(1'b0, 1);
        drain();
        request(1'b0, 0);
        drain();
        for (int k = 0; k < 19; k++) give_beat(4'b0000);
        load(9, 4, 2'b11, -1, 1'b1, 4'b0000);
        check_eq("done_all", done_mask, 4'b1111);
        for (int i = 0; i < 4; i++) m_playing[i] = 0;
        load(9, 0, 2'b11, -1, 1'b0, 4'b0000);

        // pause in the middle of a dur-5 note
        load(16, 5, 2'b01, 0, 1'b0, 4'b0001);
        step_cyc();
        m_playing[0] = 1;
        give_beat(4'b0000);
        give_beat(4'b0000);
        request(1'b0, 0);
        drain();
        play_enable = 1'b0;
        step_cyc();
        m_playing[0] = 0;
        for (int k = 0; k < 100; k++) give_beat(4'b0000);
        check_eq("busy_paused", voices_busy, 4'b0001);
        request(1'b0, 0);
        drain();
        play_enable = 1'b1;
        step_cyc();
        m_playing[0] = 1;
        request(1'b0, 0);
        drain();
        give_beat(4'b0000);
        give_beat(4'b0000);
        give_beat(4'b0001);
        m_playing[0] = 0;
        check_eq("busy_after_pause_note", voices_busy, 4'b0000);

        // request with no voices playing, duplicate request ignored
        request(1'b0, 1);
        drain();

        // reset with two voices playing and a mix in flight
        load(5, 30, 2'b11, 0, 1'b0, 4'b0001);
        load(7, 30, 2'b10, 1, 1'b0, 4'b0011);
        step_cyc();
        m_playing[0] = 1;
        m_playing[1] = 1;
        request(1'b0, 0);
        reset = 1'b1;
        sb_q.delete();
        step_cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_playing[i] = 0;
        check_eq("rst2_busy", voices_busy, 0);
        check_eq("rst2_ready", new_sample_ready, 0);
        check_eq("rst2_left", sample_left, 0);
        check_eq("rst2_right_g0", sample_right_g0, 0);
        check_eq("rst2_done", done_mask, 0);
        repeat (6) step_cyc();
        request(1'b0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/poly_note_player.md
# poly_note_player

Polyphonic, parametrised successor to the single-voice note player. It accepts note/duration/stereo loads from the song reader and allocates each to a free voice. Each voice times its note on the 1/48 s beat and drives its own frequency ROM and sine reader. A stereo mixer sums the active voices per channel and hands one left/right sample pair to the codec per request.

## Interface
Parameters:
- NUM_VOICES, 4, number of simultaneous voices (1..8)
- NOTE_W, 6, note index width (frequency ROM address)
- DUR_W, 6, duration width in beats
- SAMPLE_W, 16, signed sample width from sine reader and to codec
- GAIN_SHIFT, 2, arithmetic right shift applied to each channel sum before saturation

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play_enable  in  1  high = voices play; low = all voices pause
- load_new_note  in  1  single-cycle load strobe
- note_to_load  in  NOTE_W  note index
- duration_to_load  in  DUR_W  note length in beats
- stereo_side_to_load  in  2  bit1 = left, bit0 = right
- load_accepted  out  1  pulse: load was given to a voice
- load_rejected  out  1  pulse: load was dropped (all voices busy, or duration 0)
- voices_busy  out  NUM_VOICES  per-voice busy mask
- done_mask  out  NUM_VOICES  pulse: per-voice note finished this cycle
- beat  in  1  1/48 s beat pulse
- generate_next_sample  in  1  codec sample request pulse
- sample_left  out  SAMPLE_W  mixed left sample
- sample_right  out  SAMPLE_W  mixed right sample
- new_sample_ready  out  1  pulse: sample_left and sample_right are valid

## Operation
- Per-voice FSM states are IDLE, LOAD, PLAY and PAUSE. A voice is busy in every state except IDLE.
- Allocation: when load_new_note is high, the lowest-index IDLE voice captures note, duration and stereo. That voice goes to LOAD, count becomes duration−1, and load_accepted pulses in the same cycle as the strobe.
- A load with duration_to_load == 0 is not allocated. load_rejected pulses and no done_mask bit is set.
- A load that arrives when no voice is IDLE is dropped and load_rejected pulses.
- LOAD lasts 1 cycle, covering the 1-cycle frequency ROM latency. The voice then goes to PLAY if play_enable is high, otherwise to PAUSE. A beat during LOAD is ignored.
- PLAY:
  - If play_enable is low, go to PAUSE with count frozen.
  - Else on beat with count == 0: go to IDLE and set done_mask[i] for 1 cycle.
  - Else on beat: count decrements by 1.
- PAUSE: go to PLAY when play_enable is high. count holds and beats are ignored.
- A note of duration D stays in PLAY for exactly D beats while enabled.
- A voice freed in cycle t is allocatable from cycle t+1. A load in cycle t while voice i is finishing goes to another IDLE voice, or is rejected.
- Several voices may finish on the same beat. done_mask then carries all of their bits together.
- Sample request: on generate_next_sample, every voice in PLAY gets generate_next. A per-voice pending flag is set for each requested voice.
- Voices not in PLAY contribute 0 to the mix.
- A pending flag clears when that voice's sine reader pulses sample_ready, and its sample is latched.
- generate_next_sample arriving while a mix is still pending is ignored.
- Mix: once no flags are pending, each channel is summed over the latched voice samples whose stereo bit for that channel is set.
  - Sum width is SAMPLE_W+clog2(NUM_VOICES)+1, signed.
  - The sum is arithmetic-shifted right by GAIN_SHIFT.
  - The result is saturated to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1].
  - Outputs register, and new_sample_ready pulses once.
- A request with zero voices in PLAY still completes: both outputs are 0 and new_sample_ready pulses 2 cycles after the request.
- Reset in any state:
  - all voices go IDLE, counts and latches go to 0, pending flags clear;
  - sample_left, sample_right, new_sample_ready, done_mask, load_accepted, load_rejected and voices_busy are all 0 the cycle after reset is sampled;
  - any in-flight mix is abandoned with no ready pulse.

## Timing
- Load strobe in cycle t: load_accepted/load_rejected in cycle t (combinational from strobe and IDLE mask, registered voice state). The voice is busy from t+1, in LOAD during t+1, and in PLAY or PAUSE from t+2.
- Done: the done_mask bit is registered and pulses in the cycle after the terminal beat. The voice reads IDLE in that same cycle.
- Sample path: request in cycle t, then sine reader latency L, then pending clears. Sum and saturate take 1 registered stage, so new_sample_ready arrives at t+L+2 and is exactly 1 cycle wide.
- Beat and generate_next_sample may coincide. Both are honoured in the same cycle, and a voice finishing on that beat still contributes to that request.

## Test plan
- Reset mid-note, with 2 voices playing and a mix pending → next cycle voices_busy=0, new_sample_ready never pulses for the abandoned request, all outputs 0.
- Load note 10, dur 3, stereo 2'b11 with play_enable=1 → load_accepted at t; voices_busy=0001 from t+1; done_mask=0001 exactly 1 cycle after the 3rd beat following PLAY entry.
- NUM_VOICES=4, with 5 loads on consecutive cycles, each dur 20 → first 4 accepted into voices 0..3, 5th gives load_rejected=1; a dur=0 load after voice 2 frees also gives load_rejected.
- play_enable dropped for 100 beats in the middle of a dur-5 note → no count change, no samples generated for that voice; after re-enable, done arrives after the remaining beats only.
- Force voice samples 0x7FFF on 4 voices, all left, GAIN_SHIFT=0 → sample_left=0x7FFF (saturated), sample_right=0; with GAIN_SHIFT=2 → sample_left=0x7FFF; with voices at 0x8000, GAIN_SHIFT=0 → sample_left=0x8000.
- generate_next_sample with no busy voices → sample_left=sample_right=0 and new_sample_ready at request+2; a second request during a pending mix → ignored, only one ready pulse.
